// File: rtl/branch_resolve_queue_pkg.sv
// Shared CPU constants and the branch-queue entry record.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package branch_resolve_queue_pkg;

   localparam int DEPTH = 16;
   localparam int TAG_W = 4;

   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   typedef struct packed {
      logic        valid;
      logic        resolved;
      logic [31:0] pc;
      logic        pred_jump;
      logic [31:0] pred_target;
      logic        taken;
      logic [31:0] target;
   } brq_entry_t;

   // Wrong direction, or right direction (taken) but wrong destination.
   function automatic logic is_mispredict(input brq_entry_t e);
      return (e.taken != e.pred_jump) || (e.taken && (e.target != e.pred_target));
   endfunction

   // Where fetch must restart after a mispredict; pc+4 wraps mod 2^32.
   function automatic logic [31:0] redirect_pc(input brq_entry_t e);
      return e.taken ? e.target : (e.pc + 32'd4);
   endfunction

endpackage

// File: rtl/branch_resolve_queue_if.sv
// Fetch/execute/predictor signal bundle around the branch resolve queue.
// Latency: n/a (wires only).
// Backpressure: enq_ready gates enq_valid; resolve and predictor ports are unthrottled.
interface branch_resolve_queue_if
   import branch_resolve_queue_pkg::*;
   #(parameter int TAG_W = branch_resolve_queue_pkg::TAG_W);

   logic             enq_valid;
   logic [31:0]      enq_pc;
   logic [31:0]      enq_pred_target;
   logic             enq_pred_jump;
   logic             enq_ready;
   logic [TAG_W-1:0] enq_tag;

   logic             res_valid;
   logic             res_taken;
   logic [TAG_W-1:0] res_tag;
   logic [31:0]      res_target;

   logic             en_signal_to_pred;
   logic             hit_to_pred;
   logic [31:0]      pc_to_pred;
   logic             flush_out;
   logic [31:0]      flush_pc;

   // master: fetch/execute side driving the queue
   modport master (
      output enq_valid, enq_pc, enq_pred_target, enq_pred_jump,
      output res_valid, res_taken, res_tag, res_target,
      input  enq_ready, enq_tag,
      input  en_signal_to_pred, hit_to_pred, pc_to_pred, flush_out, flush_pc
   );

   // slave: the queue itself
   modport slave (
      input  enq_valid, enq_pc, enq_pred_target, enq_pred_jump,
      input  res_valid, res_taken, res_tag, res_target,
      output enq_ready, enq_tag,
      output en_signal_to_pred, hit_to_pred, pc_to_pred, flush_out, flush_pc
   );

endinterface

// File: rtl/branch_resolve_queue_entry_ram.sv
// Entry store: one write port (tail), one resolve port, one clear port, async head read.
// Latency: writes visible the cycle after; head read is combinational.
// Backpressure: none; the caller gates every port (enable, full, flush).
module brq_entry_ram
   import branch_resolve_queue_pkg::*;
#(
   parameter int DEPTH = branch_resolve_queue_pkg::DEPTH,
   parameter int TAG_W = branch_resolve_queue_pkg::TAG_W
) (
   input  logic             clk_in,
   input  logic             rst_in,
   // allocate at tail
   input  logic             wr_en,
   input  logic [TAG_W-1:0] wr_idx,
   input  logic [31:0]      wr_pc,
   input  logic             wr_pred_jump,
   input  logic [31:0]      wr_pred_target,
   // execute outcome
   input  logic             rs_en,
   input  logic [TAG_W-1:0] rs_idx,
   input  logic             rs_taken,
   input  logic [31:0]      rs_target,
   // retire one entry / drop everything
   input  logic             clr_en,
   input  logic [TAG_W-1:0] clr_idx,
   input  logic             clr_all,
   // head read
   input  logic [TAG_W-1:0] rd_idx,
   output brq_entry_t       rd_entry
);

   brq_entry_t mem [DEPTH];

   // Only valid/resolved need clearing; payload is don't-care while invalid.
   always_ff @(posedge clk_in) begin
      if (rst_in || clr_all) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i].valid    <= 1'b0;
            mem[i].resolved <= 1'b0;
         end
      end else begin
         if (clr_en) begin
            mem[clr_idx].valid    <= 1'b0;
            mem[clr_idx].resolved <= 1'b0;
         end
         // Late or duplicate outcomes (stale tag, already resolved) are dropped.
         if (rs_en && mem[rs_idx].valid && !mem[rs_idx].resolved) begin
            mem[rs_idx].resolved <= 1'b1;
            mem[rs_idx].taken    <= rs_taken;
            mem[rs_idx].target   <= rs_target;
         end
         // Tail never aliases head-being-cleared or a live entry: enqueue is
         // blocked when full, and an empty head is never committed.
         if (wr_en) begin
            mem[wr_idx] <= '{valid:       1'b1,
                             resolved:    1'b0,
                             pc:          wr_pc,
                             pred_jump:   wr_pred_jump,
                             pred_target: wr_pred_target,
                             taken:       1'b0,
                             target:      32'd0};
         end
      end
   end

   assign rd_entry = mem[rd_idx];

endmodule

// File: rtl/branch_resolve_queue.sv
// In-order branch resolve queue: tags predicted branches, collects out-of-order
// outcomes, commits the head in order and pulses predictor update / flush.
// Latency: res_valid in cycle t -> en_signal_to_pred/flush_out in t+2. Backpressure:
// enq_ready low when full (registered count); rdy_in=0 freezes everything.
// Ports: clk_in, rst_in (sync, active high), rdy_in (global enable), brq (slave bundle).
module branch_resolve_queue
   import branch_resolve_queue_pkg::*;
#(
   parameter int DEPTH = branch_resolve_queue_pkg::DEPTH,
   parameter int TAG_W = branch_resolve_queue_pkg::TAG_W
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  rdy_in,
   branch_resolve_queue_if.slave brq
);

   logic [TAG_W-1:0] head;
   logic [TAG_W-1:0] tail;
   logic [TAG_W:0]   count;
   brq_entry_t       head_entry;

   logic enq_ready_int;
   logic do_enq;
   logic do_res;
   logic do_commit;
   logic do_flush;

   logic        en_q;
   logic        hit_q;
   logic [31:0] pc_q;
   logic        flush_q;
   logic [31:0] flush_pc_q;

   // Full is judged on registered count, so a same-cycle commit never frees a slot.
   assign enq_ready_int = (count < (TAG_W+1)'(DEPTH));

   // Commit uses only registered entry state: an outcome arriving this cycle
   // cannot retire until next cycle, which fixes the t+2 pulse latency.
   assign do_commit = rdy_in && head_entry.valid && head_entry.resolved;
   assign do_flush  = do_commit && is_mispredict(head_entry);
   assign do_enq    = rdy_in && brq.enq_valid && enq_ready_int && !do_flush;
   assign do_res    = rdy_in && brq.res_valid && !do_flush;

   brq_entry_ram #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_ram (
      .clk_in         (clk_in),
      .rst_in         (rst_in),
      .wr_en          (do_enq),
      .wr_idx         (tail),
      .wr_pc          (brq.enq_pc),
      .wr_pred_jump   (brq.enq_pred_jump),
      .wr_pred_target (brq.enq_pred_target),
      .rs_en          (do_res),
      .rs_idx         (brq.res_tag),
      .rs_taken       (brq.res_taken),
      .rs_target      (brq.res_target),
      .clr_en         (do_commit),
      .clr_idx        (head),
      .clr_all        (do_flush),
      .rd_idx         (head),
      .rd_entry       (head_entry)
   );

   always_ff @(posedge clk_in) begin
      if (rst_in || do_flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (do_enq)    tail <= tail + TAG_W'(1);
         if (do_commit) head <= head + TAG_W'(1);
         count <= count + {{TAG_W{1'b0}}, do_enq} - {{TAG_W{1'b0}}, do_commit};
      end
   end

   // Pulses self-clear every cycle; payloads hold their last committed value.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         en_q       <= 1'b0;
         hit_q      <= 1'b0;
         pc_q       <= '0;
         flush_q    <= 1'b0;
         flush_pc_q <= '0;
      end else begin
         en_q    <= do_commit;
         flush_q <= do_flush;
         if (do_commit) begin
            hit_q <= head_entry.taken;
            pc_q  <= head_entry.pc;
         end
         if (do_flush) begin
            flush_pc_q <= redirect_pc(head_entry);
         end
      end
   end

   assign brq.enq_ready         = enq_ready_int;
   assign brq.enq_tag           = tail;
   // Pulses are masked while stalled so downstream never sees an update then.
   assign brq.en_signal_to_pred = en_q & rdy_in;
   assign brq.flush_out         = flush_q & rdy_in;
   assign brq.hit_to_pred       = hit_q;
   assign brq.pc_to_pred        = pc_q;
   assign brq.flush_pc          = flush_pc_q;

endmodule

// File: doc/branch_resolve_queue.md
BRANCH_RESOLVE_QUEUE -- requirements
Module: branch_resolve_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of in-flight branch entries (power of two).
REQ-002 SHALL have parameter TAG_W, default 4, equal to log2(DEPTH).
REQ-003 SHALL have one clock and a synchronous, active-high reset, named as below.
REQ-004 clk_in  input  1  clock; all state updates on its rising edge.
REQ-005 rst_in  input  1  synchronous active-high reset.
REQ-006 rdy_in  input  1  global enable; when 0, all state freezes.
REQ-007 enq_valid  input  1  fetch stage presents a predicted branch or JAL.
REQ-008 enq_pc, enq_pred_target  input  32 each  branch PC; predicted target (PC plus immediate).
REQ-009 enq_pred_jump  input  1  predicted-taken flag.
REQ-010 enq_ready  output  1  high while count < DEPTH.
REQ-011 enq_tag  output  TAG_W  tail index the next accepted entry receives.
REQ-012 res_valid, res_taken  input  1 each  execute-stage outcome valid; actual taken.
REQ-013 res_tag  input  TAG_W; res_target  input  32  entry addressed; actual target.
REQ-014 en_signal_to_pred, hit_to_pred  output  1 each  one-cycle predictor-update pulse; actual taken (1 moves counter toward jump).
REQ-015 pc_to_pred  output  32  PC of the committed branch.
REQ-016 flush_out  output  1; flush_pc  output  32  one-cycle mispredict pulse; redirect address.

Function
REQ-017 SHALL be a circular queue with head, tail and count registers; each entry holds valid, resolved, pc, pred_jump, pred_target, taken and target.
REQ-018 SHALL accept an entry when enq_valid && enq_ready && rdy_in: write it at tail with valid=1 and resolved=0, then advance tail modulo DEPTH.
REQ-019 SHALL compute enq_ready from the registered count; a commit in the same cycle does not free space for an enqueue at full.
REQ-020 SHALL, on res_valid && rdy_in for a valid entry, set resolved=1 and store taken and target; resolve to an invalid or already-resolved tag is ignored.
REQ-021 SHALL commit at most one entry per cycle, only the head, only when it is valid && resolved in registered state; commit clears the entry, advances head and decrements count.
REQ-022 SHALL, on commit, register en_signal_to_pred=1, pc_to_pred=entry pc, hit_to_pred=entry taken for exactly one cycle; latency is res_valid in cycle t, pulse in cycle t+2.
REQ-023 SHALL define a mispredict as taken != pred_jump, or taken && target != pred_target.
REQ-024 SHALL, on mispredicted commit, additionally pulse flush_out with flush_pc = target if taken, else pc+4 (mod 2^32).
REQ-025 SHALL, on mispredicted commit, clear all valid bits and set head=tail=count=0; same-cycle enqueue and resolve are discarded.
REQ-026 SHALL apply simultaneous enqueue and non-flushing commit together, leaving count unchanged.
REQ-027 SHALL, while rdy_in=0, hold all state and drive en_signal_to_pred=0 and flush_out=0.

Reset
REQ-028 SHALL, on rst_in, clear all valid and resolved bits, set head=tail=count=0, drive en_signal_to_pred=hit_to_pred=flush_out=0 and pc_to_pred=flush_pc=0, and give rst_in priority over every other input, including mid-commit.

Structure
REQ-029 SHALL place DEPTH, TAG_W and the opcode constants JAL=1101111 and BRANCH=1100011 in the shared CPU package.
REQ-030 SHALL be a single module; the entry store may be one sub-module, brq_entry_ram, with 1 write, 1 resolve and 1 head read port.

Verification
REQ-031 Enqueue pc=0x100, pred_jump=1, target=0x140; resolve taken=1, target=0x140 -> en pulse, pc_to_pred=0x100, hit=1, no flush.
REQ-032 Enqueue pc=0x200, pred_jump=1; resolve taken=0 -> en pulse with hit=0, flush_out=1, flush_pc=0x204, count=0.
REQ-033 Enqueue 16 entries -> enq_ready=0; 17th enq_valid is refused; resolve tag 0 -> one commit, then enq_ready=1.
REQ-034 Enqueue tags 0,1; resolve tag 1 first -> no commit; resolve tag 0 -> commits for 0 then 1 in consecutive cycles.
REQ-035 Assert rst_in in the same cycle a mispredicted commit is pending -> all outputs 0, queue empty, no flush pulse.
REQ-036 Hold rdy_in=0 with resolved head -> no pulse; raise rdy_in -> pulse in the following cycle.
